// File: rtl/nec_mul_pkg.sv
// Shared types and constants for the shift-add multiplier.
// MULTIPLIER_RADIX4_EN selects 2 multiplier bits per step instead of 1.
package nec_mul_pkg;

    typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_FIN} mul_state_t;

    localparam int unsigned MUL_WIDTH  = 16;
    localparam int unsigned MUL_NARROW = 8;
    localparam int unsigned MUL_CNT_W  = $clog2(MUL_WIDTH) + 1;

    localparam int unsigned MUL_ITERS_WIDE_R2   = MUL_WIDTH;
    localparam int unsigned MUL_ITERS_NARROW_R2 = MUL_NARROW;
    localparam int unsigned MUL_ITERS_WIDE_R4   = MUL_WIDTH / 2;
    localparam int unsigned MUL_ITERS_NARROW_R4 = MUL_NARROW / 2;

`ifdef MULTIPLIER_RADIX4_EN
    localparam int unsigned MUL_BITS_PER_STEP = 2;
    localparam int unsigned MUL_ITERS_WIDE    = MUL_ITERS_WIDE_R4;
    localparam int unsigned MUL_ITERS_NARROW  = MUL_ITERS_NARROW_R4;
`else
    localparam int unsigned MUL_BITS_PER_STEP = 1;
    localparam int unsigned MUL_ITERS_WIDE    = MUL_ITERS_WIDE_R2;
    localparam int unsigned MUL_ITERS_NARROW  = MUL_ITERS_NARROW_R2;
`endif

endpackage

// File: rtl/multiplier2_if.sv
// Start/done handshake and operand/result bundle for multiplier2.
interface multiplier2_if
    import nec_mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH
) ();

    logic               ce;
    logic               start;
    logic               wide;
    logic               is_signed;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;
    logic               overflow;

    modport master (
        output ce, start, wide, is_signed, a, b,
        input  busy, done, product, overflow
    );

    modport slave (
        input  ce, start, wide, is_signed, a, b,
        output busy, done, product, overflow
    );

endinterface

// File: rtl/mul_step.sv
// One shift-add iteration: adds the shifted partial product selected by the multiplier bit(s).
// MULTIPLIER_RADIX4_EN switches to 2 bits per step using a precomputed 3x multiplicand.
module mul_step
    import nec_mul_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_WIDTH,
    parameter int unsigned CNT_W = MUL_CNT_W
) (
    input  logic [2*WIDTH-1:0]           i_acc,
    input  logic [2*WIDTH-1:0]           i_mag_a,
`ifdef MULTIPLIER_RADIX4_EN
    input  logic [2*WIDTH-1:0]           i_mag_a3,
`endif
    input  logic [MUL_BITS_PER_STEP-1:0] i_bits,
    input  logic [CNT_W-1:0]             i_idx,
    output logic [2*WIDTH-1:0]           o_acc
);

    logic [2*WIDTH-1:0] w_pp;

`ifdef MULTIPLIER_RADIX4_EN
    always_comb begin
        case (i_bits)
            2'd0:    w_pp = '0;
            2'd1:    w_pp = i_mag_a;
            2'd2:    w_pp = i_mag_a << 1;
            default: w_pp = i_mag_a3;
        endcase
        o_acc = i_acc + (w_pp << {i_idx, 1'b0});
    end
`else
    always_comb begin
        w_pp  = i_bits[0] ? i_mag_a : '0;
        o_acc = i_acc + (w_pp << i_idx);
    end
`endif

endmodule

// File: rtl/multiplier2.sv
// Sequential MUL/IMUL: magnitude shift-add with sign fix-up and CF/OF overflow flag.
// Build with MULTIPLIER_RADIX4_EN for the 2-bits-per-step variant.
module multiplier2
    import nec_mul_pkg::*;
#(
    parameter int unsigned WIDTH  = MUL_WIDTH,
    parameter int unsigned NARROW = MUL_NARROW
) (
    input logic          clk,
    input logic          reset,
    multiplier2_if.slave bus
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = MUL_CNT_W;

    mul_state_t r_state, w_state_nxt;

    logic [WIDTH-1:0] r_mag_a, r_mag_b;
`ifdef MULTIPLIER_RADIX4_EN
    logic [PW-1:0]    r_mag_a3;
`endif
    logic             r_wide, r_signed, r_neg;
    logic [PW-1:0]    r_acc, r_product;
    logic [CNT_W-1:0] r_count;
    logic             r_busy, r_done, r_overflow;

    logic [WIDTH-1:0] w_ext_a, w_ext_b, w_mag_a, w_mag_b;
    logic             w_sign_a, w_sign_b;
    logic [CNT_W-1:0] w_idx;
    logic [MUL_BITS_PER_STEP-1:0] w_bits;
    logic [PW-1:0]    w_step_acc, w_res, w_prod;
    logic             w_ovf;

    logic [PW-1:0]    w_acc_nxt, w_product_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_busy_nxt, w_done_nxt, w_overflow_nxt;

    // Narrow operands come from the low byte, extended according to signedness.
    always_comb begin
        if (bus.wide) begin
            w_ext_a = bus.a;
            w_ext_b = bus.b;
        end else begin
            w_ext_a = {{(WIDTH-NARROW){bus.is_signed & bus.a[NARROW-1]}}, bus.a[NARROW-1:0]};
            w_ext_b = {{(WIDTH-NARROW){bus.is_signed & bus.b[NARROW-1]}}, bus.b[NARROW-1:0]};
        end
        w_sign_a = bus.is_signed & w_ext_a[WIDTH-1];
        w_sign_b = bus.is_signed & w_ext_b[WIDTH-1];
        w_mag_a  = w_sign_a ? -w_ext_a : w_ext_a;
        w_mag_b  = w_sign_b ? -w_ext_b : w_ext_b;
    end

    always_comb begin
        w_idx = (r_wide ? CNT_W'(MUL_ITERS_WIDE) : CNT_W'(MUL_ITERS_NARROW)) - r_count;
`ifdef MULTIPLIER_RADIX4_EN
        w_bits = MUL_BITS_PER_STEP'(r_mag_b >> {w_idx, 1'b0});
`else
        w_bits = MUL_BITS_PER_STEP'(r_mag_b >> w_idx);
`endif
    end

    mul_step #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step (
        .i_acc    (r_acc),
        .i_mag_a  ({{WIDTH{1'b0}}, r_mag_a}),
`ifdef MULTIPLIER_RADIX4_EN
        .i_mag_a3 (r_mag_a3),
`endif
        .i_bits   (w_bits),
        .i_idx    (w_idx),
        .o_acc    (w_step_acc)
    );

    always_comb begin
        w_res = r_neg ? -r_acc : r_acc;
        if (r_wide) begin
            w_prod = w_res;
            w_ovf  = r_signed ? (w_res[PW-1:WIDTH] != {WIDTH{w_res[WIDTH-1]}})
                              : (w_res[PW-1:WIDTH] != '0);
        end else begin
            w_prod = {{(PW-2*NARROW){1'b0}}, w_res[2*NARROW-1:0]};
            w_ovf  = r_signed ? (w_res[2*NARROW-1:NARROW] != {NARROW{w_res[NARROW-1]}})
                              : (w_res[2*NARROW-1:NARROW] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MUL_IDLE;
        end else if (bus.ce) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.start) begin
            w_state_nxt = MUL_RUN;
        end else begin
            case (r_state)
                MUL_RUN: if (r_count == CNT_W'(1)) w_state_nxt = MUL_FIN;
                MUL_FIN: w_state_nxt = MUL_IDLE;
                default: w_state_nxt = MUL_IDLE;
            endcase
        end
    end

    always_comb begin
        w_acc_nxt      = r_acc;
        w_count_nxt    = r_count;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_product_nxt  = r_product;
        w_overflow_nxt = r_overflow;
        if (bus.start) begin
            w_acc_nxt   = '0;
            w_count_nxt = bus.wide ? CNT_W'(MUL_ITERS_WIDE) : CNT_W'(MUL_ITERS_NARROW);
            w_busy_nxt  = 1'b1;
            w_done_nxt  = 1'b0;
        end else begin
            case (r_state)
                MUL_RUN: begin
                    w_acc_nxt   = w_step_acc;
                    w_count_nxt = r_count - CNT_W'(1);
                end
                MUL_FIN: begin
                    w_product_nxt  = w_prod;
                    w_overflow_nxt = w_ovf;
                    w_done_nxt     = 1'b1;
                    w_busy_nxt     = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_count    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_product  <= '0;
            r_overflow <= 1'b0;
            r_mag_a    <= '0;
            r_mag_b    <= '0;
`ifdef MULTIPLIER_RADIX4_EN
            r_mag_a3   <= '0;
`endif
            r_wide     <= 1'b0;
            r_signed   <= 1'b0;
            r_neg      <= 1'b0;
        end else if (bus.ce) begin
            r_acc      <= w_acc_nxt;
            r_count    <= w_count_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_product  <= w_product_nxt;
            r_overflow <= w_overflow_nxt;
            if (bus.start) begin
                r_mag_a  <= w_mag_a;
                r_mag_b  <= w_mag_b;
`ifdef MULTIPLIER_RADIX4_EN
                r_mag_a3 <= ({{WIDTH{1'b0}}, w_mag_a} << 1) + {{WIDTH{1'b0}}, w_mag_a};
`endif
                r_wide   <= bus.wide;
                r_signed <= bus.is_signed;
                r_neg    <= w_sign_a ^ w_sign_b;
            end
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.product  = r_product;
    assign bus.overflow = r_overflow;

endmodule
